// File: rtl/sqrt_error_monitor.sv
// sqrt_error_monitor: accumulates error statistics (count, sum, max, optional bias) of an approximate sqrt against an exact one
// Ports: clk/rst (async active-high), start pulse begins a run of NUM_SAMPLES pairs;
//   in_valid/in_ready handshake on q_approx/q_exact; busy (RUN/FLUSH), done (DONE);
//   sample_count, err_count, ed_sum, ed_max results; bias_sum exists only with SQRT_ERR_BIAS_EN defined.
module sqrt_error_monitor #(
  parameter int Q_W = 8,
  parameter int CNT_W = 17,
  parameter int NUM_SAMPLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_W-1:0]       q_approx,
  input  logic [Q_W-1:0]       q_exact,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W+Q_W-1:0] ed_sum,
  output logic [Q_W-1:0]       ed_max
`ifdef SQRT_ERR_BIAS_EN
  ,
  output logic signed [CNT_W+Q_W:0] bias_sum
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] acc_cnt;
  logic flush_cnt;
  logic accept, go, last;
  logic [Q_W-1:0] diff, diff1;
  logic mis1, v1;
  assign accept = in_valid && in_ready;
  assign go = start && (state == IDLE || state == DONE);
  assign last = accept && acc_cnt == CNT_W'(NUM_SAMPLES - 1);
  assign diff = q_approx > q_exact ? q_approx - q_exact : q_exact - q_approx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      acc_cnt <= '0;
      flush_cnt <= 1'b0;
    end else if (go) begin
      state <= RUN;
      in_ready <= 1'b1;
      busy <= 1'b1;
      done <= 1'b0;
      acc_cnt <= '0;
    end else if (state == RUN) begin
      if (accept) acc_cnt <= acc_cnt + 1'b1;
      if (last) begin
        state <= FLUSH;
        in_ready <= 1'b0;
        flush_cnt <= 1'b0;
      end
    end else if (state == FLUSH) begin
      flush_cnt <= 1'b1;
      if (flush_cnt) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
`ifdef SQRT_ERR_BIAS_EN
  logic signed [Q_W:0] sdiff1;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      diff1 <= '0;
      mis1 <= 1'b0;
      sample_count <= '0;
      err_count <= '0;
      ed_sum <= '0;
      ed_max <= '0;
`ifdef SQRT_ERR_BIAS_EN
      sdiff1 <= '0;
      bias_sum <= '0;
`endif
    end else if (go) begin
      v1 <= 1'b0;
      diff1 <= '0;
      mis1 <= 1'b0;
      sample_count <= '0;
      err_count <= '0;
      ed_sum <= '0;
      ed_max <= '0;
`ifdef SQRT_ERR_BIAS_EN
      sdiff1 <= '0;
      bias_sum <= '0;
`endif
    end else begin
      v1 <= accept;
      diff1 <= diff;
      mis1 <= q_approx != q_exact;
`ifdef SQRT_ERR_BIAS_EN
      sdiff1 <= $signed({1'b0, q_approx}) - $signed({1'b0, q_exact});
`endif
      if (v1) begin
        sample_count <= sample_count + 1'b1;
        err_count <= err_count + CNT_W'(mis1);
        ed_sum <= ed_sum + (CNT_W+Q_W)'(diff1);
        if (diff1 > ed_max) ed_max <= diff1;
`ifdef SQRT_ERR_BIAS_EN
        bias_sum <= bias_sum + (CNT_W+Q_W+1)'(sdiff1);
`endif
      end
    end
  end
endmodule
